legv8_instr_encoder: RTL and testbench
======================================

// Module: legv8_instr_encoder
// PURPOSE
//  Inverse of the main control decoder. Takes a symbolic LEGv8 instruction (mnemonic, registers, immediate)
//  and packs it into the 32-bit machine word. Writes that word to instruction memory at an auto-incrementing
//  byte address. Serves as the program loader in front of instruction memory, for self-test and bring-up.
// PARAMETERS
//  ADDR_WIDTH  8   byte-address width of oMemAddr/oCount
//  BASE_ADDR   0   first byte address written after iStart
//  MEM_WORDS   64  capacity in words; constraint BASE_ADDR+4*MEM_WORDS <= 2**ADDR_WIDTH
// PORTS
//  iCLK      in   1           clock, rising edge
//  iRST_n    in   1           reset, synchronous, active-low
//  iStart    in   1           begin new program: pointer<=BASE_ADDR, counters/errors cleared
//  iValid    in   1           instruction fields valid
//  oReady    out  1           encoder accepts fields this cycle
//  iMnem     in   4           0 ADD,1 SUB,2 AND,3 ORR,4 LDUR,5 STUR,6 CBZ,7 B,8 BL,9 BR; 10-15 illegal
//  iRd       in   5           Rd (R-type) / Rt (LDUR, STUR, CBZ)
//  iRn       in   5           Rn (R-type, D-type, BR target)
//  iRm       in   5           Rm (R-type only)
//  iImm      in   32          signed immediate: byte offset (D-type) or word offset (CBZ/B/BL)
//  iLast     in   1           qualifies iValid: final instruction of program
//  oMemWE    out  1           instruction-memory write request
//  oMemAddr  out  ADDR_WIDTH  write byte address
//  oMemData  out  32          encoded instruction
//  iMemAck   in   1           memory accepted write (sampled while oMemWE=1)
//  oDone     out  1           program complete (level, until iStart or reset)
//  oErr      out  1           sticky: some instruction was dropped
//  oErrCode  out  2           first error: 00 none,01 illegal mnem,10 imm out of range,11 memory full
//  oCount    out  ADDR_WIDTH  words written since iStart
// BEHAVIOUR
//  Reset (iRST_n=0 at edge): state IDLE; oReady, oMemWE, oDone, oErr = 0; oErrCode, oCount, oMemData = 0;
//    oMemAddr = BASE_ADDR. A write in progress is abandoned.
//  States: IDLE, ACCEPT, WRITE, DONE. oReady=1 only in ACCEPT.
//  IDLE/DONE + iStart -> ACCEPT: pointer=BASE_ADDR, oCount=0, oErr=0, oErrCode=00, oDone=0.
//  ACCEPT + iStart -> restart as above; iValid ignored that cycle. In WRITE, iStart is ignored.
//  ACCEPT + iValid: checks applied in priority order illegal > range > full.
//    On failure: drop; set oErr; oErrCode loads only if currently 00 (first error sticky).
//      Next state DONE if iLast, else ACCEPT.
//    On success: latch encoded word into oMemData, latch iLast; ACCEPT -> WRITE.
//  WRITE: oMemWE=1, oMemAddr/oMemData held stable until iMemAck=1 at an edge.
//    On ack: pointer+=4, oCount+=1, go DONE if latched last else ACCEPT; oMemWE=0 the next cycle.
//    Latency: fields accepted at edge N -> oMemWE=1 in cycle N+1. Max throughput 1 word / 2 cycles.
//  Full: pointer==BASE_ADDR+4*MEM_WORDS -> code 11. The pointer never wraps.
//  Encoding (opcodes are those of the control decoder):
//    R:  {op11, Rm, 6'b0, Rn, Rd}. ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
//    BR: {11010110000, 5'b11111, 6'b0, Rn, 5'b0}.
//    D:  {op11, imm[8:0], 2'b00, Rn, Rt}. LDUR 11111000010, STUR 11111000000. Range -256..255.
//    CB: {10110100, imm[18:0], Rt}. Range -2^18..2^18-1.
//    B:  {000101, imm[25:0]}; BL {100101, imm[25:0]} (X30 implicit). Range -2^25..2^25-1.
//    iImm ignored for R-type/BR. Unused register fields ignored.
//  DONE: oDone=1; iValid ignored.
// TESTING
//  ADD Rd=1,Rn=2,Rm=3 -> oMemWE next cycle, addr 0x00, data 0x8B030041; oCount=1.
//  LDUR Rt=5,Rn=6,imm=-8 -> 0xF85F80C5 @0x04. CBZ Rt=9,imm=-2 -> 0xB4FFFFC9 @0x08.
//  B imm=16 -> 0x14000010. BL imm=16 -> 0x94000010. BR Rn=30 -> 0xD61F03C0.
//  LDUR imm=256 -> no write, oErr=1, code 10; then iMnem=12 -> code stays 10; next valid ADD still writes.
//  MEM_WORDS=2, three ADDs -> third dropped with code 11; iLast on third -> oDone=1.
//    iStart then clears oDone/oErr, oCount=0.
//  iMemAck held low 5 cycles -> oMemWE/addr/data stable, oReady=0. Reset mid-WRITE -> all outputs at reset values.

Source files
------------

// File: rtl/legv8_instr_encoder.sv
// legv8_instr_encoder: packs symbolic LEGv8 instructions into machine words and loads them into instruction memory
module legv8_instr_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0,
  parameter int MEM_WORDS  = 64
) (
  input  logic                  iCLK,
  input  logic                  iRST_n,
  input  logic                  iStart,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [3:0]            iMnem,
  input  logic [4:0]            iRd,
  input  logic [4:0]            iRn,
  input  logic [4:0]            iRm,
  input  logic [31:0]           iImm,
  input  logic                  iLast,
  output logic                  oMemWE,
  output logic [ADDR_WIDTH-1:0] oMemAddr,
  output logic [31:0]           oMemData,
  input  logic                  iMemAck,
  output logic                  oDone,
  output logic                  oErr,
  output logic [1:0]            oErrCode,
  output logic [ADDR_WIDTH-1:0] oCount
);
  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;
  // one extra pointer bit so the full limit is representable and never wraps
  localparam logic [ADDR_WIDTH:0] BASE  = (ADDR_WIDTH+1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(BASE_ADDR + 4*MEM_WORDS);
  state_t state, state_nx;
  logic [ADDR_WIDTH:0] ptr;
  logic [31:0] word;
  logic [1:0] code;
  logic oor, last_q;
  always_comb begin
    word = '0;
    oor = 1'b0;
    case (iMnem)
      4'd0: word = {11'b10001011000, iRm, 6'b0, iRn, iRd};
      4'd1: word = {11'b11001011000, iRm, 6'b0, iRn, iRd};
      4'd2: word = {11'b10001010000, iRm, 6'b0, iRn, iRd};
      4'd3: word = {11'b10101010000, iRm, 6'b0, iRn, iRd};
      4'd4: begin
        word = {11'b11111000010, iImm[8:0], 2'b00, iRn, iRd};
        oor = $signed(iImm) < -256 || $signed(iImm) > 255;
      end
      4'd5: begin
        word = {11'b11111000000, iImm[8:0], 2'b00, iRn, iRd};
        oor = $signed(iImm) < -256 || $signed(iImm) > 255;
      end
      4'd6: begin
        word = {8'b10110100, iImm[18:0], iRd};
        oor = $signed(iImm) < -(1 << 18) || $signed(iImm) > (1 << 18) - 1;
      end
      4'd7: begin
        word = {6'b000101, iImm[25:0]};
        oor = $signed(iImm) < -(1 << 25) || $signed(iImm) > (1 << 25) - 1;
      end
      4'd8: begin
        word = {6'b100101, iImm[25:0]};
        oor = $signed(iImm) < -(1 << 25) || $signed(iImm) > (1 << 25) - 1;
      end
      4'd9: word = {11'b11010110000, 5'b11111, 6'b0, iRn, 5'b0};
      default: ;
    endcase
    code = iMnem > 4'd9 ? 2'b01 : oor ? 2'b10 : ptr == LIMIT ? 2'b11 : 2'b00;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = iStart ? ACCEPT : state;
      ACCEPT: state_nx = iStart ? ACCEPT : !iValid ? ACCEPT : code == 2'b00 ? WRITE : iLast ? DONE : ACCEPT;
      WRITE: state_nx = !iMemAck ? WRITE : last_q ? DONE : ACCEPT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge iCLK)
    if (!iRST_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      ptr <= BASE;
      oCount <= '0;
      oMemData <= '0;
      last_q <= 1'b0;
      oErr <= 1'b0;
      oErrCode <= 2'b00;
    end else if (iStart && state != WRITE) begin
      ptr <= BASE;
      oCount <= '0;
      oErr <= 1'b0;
      oErrCode <= 2'b00;
    end else if (state == ACCEPT && iValid) begin
      if (code != 2'b00) begin
        oErr <= 1'b1;
        if (oErrCode == 2'b00) oErrCode <= code;
      end else begin
        oMemData <= word;
        last_q <= iLast;
      end
    end else if (state == WRITE && iMemAck) begin
      ptr <= ptr + (ADDR_WIDTH+1)'(4);
      oCount <= oCount + 1'b1;
    end
  end
  assign oReady = state == ACCEPT;
  assign oMemWE = state == WRITE;
  assign oDone = state == DONE;
  assign oMemAddr = ptr[ADDR_WIDTH-1:0];
endmodule

// File: tb/tb_legv8_instr_encoder.sv
// tb_legv8_instr_encoder: directed and random program loads checked against an arithmetic encoding model
module tb_legv8_instr_encoder;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, valid = 1'b0, last = 1'b0, ack = 1'b0;
  logic [3:0] mnem = '0;
  logic [4:0] rd = '0, rn = '0, rm = '0;
  logic [31:0] imm = '0;
  logic ready, we, done, err;
  logic [7:0] addr, count;
  logic [31:0] data;
  logic [1:0] errcode;
  int total = 0, bad = 0;
  int m_cnt = 0, m_code = 0;
  int unsigned opc [10] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
                            11'b11111000010, 11'b11111000000, 8'b10110100, 6'b000101, 6'b100101,
                            11'b11010110000};

  legv8_instr_encoder dut (
    .iCLK(clk), .iRST_n(rst_n), .iStart(start), .iValid(valid), .oReady(ready),
    .iMnem(mnem), .iRd(rd), .iRn(rn), .iRm(rm), .iImm(imm), .iLast(last),
    .oMemWE(we), .oMemAddr(addr), .oMemData(data), .iMemAck(ack),
    .oDone(done), .oErr(err), .oErrCode(errcode), .oCount(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint modp(input longint v, input longint m);
    return ((v % m) + m) % m;
  endfunction

  function automatic logic [31:0] model_word(input int mn, rdv, rnv, rmv, immv);
    longint w = 0;
    longint op = longint'(opc[mn % 10]);
    if (mn <= 3) w = op * (1 << 21) + rmv * (1 << 16) + rnv * 32 + rdv;
    else if (mn <= 5) w = op * (1 << 21) + modp(immv, 512) * (1 << 12) + rnv * 32 + rdv;
    else if (mn == 6) w = op * (1 << 24) + modp(immv, 1 << 19) * 32 + rdv;
    else if (mn <= 8) w = op * (1 << 26) + modp(immv, 1 << 26);
    else w = op * (1 << 21) + 31 * (1 << 16) + rnv * 32;
    return w[31:0];
  endfunction

  function automatic int exp_code(input int mn, immv);
    longint lo = 0, hi = 0;
    if (mn > 9) return 1;
    if (mn == 4 || mn == 5) begin lo = -256; hi = 255; end
    else if (mn == 6) begin lo = -(1 << 18); hi = (1 << 18) - 1; end
    else if (mn == 7 || mn == 8) begin lo = -(1 << 25); hi = (1 << 25) - 1; end
    if ((mn >= 4 && mn <= 8) && (immv < lo || immv > hi)) return 2;
    if (m_cnt == 64) return 3;
    return 0;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic restart;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_cnt = 0;
    m_code = 0;
    chk("restart_ready", 32'(ready), 1);
    chk("restart_done", 32'(done), 0);
    chk("restart_err", 32'(err), 0);
    chk("restart_code", 32'(errcode), 0);
    chk("restart_count", 32'(count), 0);
    chk("restart_addr", 32'(addr), 0);
  endtask

  task automatic send(input int mn, rdv, rnv, rmv, immv, input bit lst, input int dly);
    int n = 0;
    int c = exp_code(mn, immv);
    logic [31:0] w = model_word(mn, rdv, rnv, rmv, immv);
    while (!ready && n < 20) begin tick(); n++; end
    chk("ready_wait", 32'(ready), 1);
    mnem = 4'(mn); rd = 5'(rdv); rn = 5'(rnv); rm = 5'(rmv); imm = 32'(immv);
    valid = 1'b1; last = lst;
    tick();
    valid = 1'b0; last = 1'b0;
    if (c == 0) begin
      chk("wr_we", 32'(we), 1);
      chk("wr_ready", 32'(ready), 0);
      chk("wr_addr", 32'(addr), 32'(m_cnt * 4));
      chk("wr_data", data, w);
      for (int i = 0; i < dly; i++) begin
        tick();
        chk("hold_we", 32'(we), 1);
        chk("hold_ready", 32'(ready), 0);
        chk("hold_addr", 32'(addr), 32'(m_cnt * 4));
        chk("hold_data", data, w);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      m_cnt++;
      chk("ack_we", 32'(we), 0);
      chk("ack_count", 32'(count), 32'(m_cnt));
    end else begin
      if (m_code == 0) m_code = c;
      chk("drop_we", 32'(we), 0);
      chk("drop_err", 32'(err), 1);
      chk("drop_code", 32'(errcode), 32'(m_code));
      chk("drop_count", 32'(count), 32'(m_cnt));
    end
    chk("done_level", 32'(done), 32'(lst));
  endtask

  task automatic send_rand;
    int mn = $urandom_range(0, 9);
    int iv = int'($urandom);
    if (mn == 4 || mn == 5) iv = int'($urandom_range(0, 511)) - 256;
    else if (mn == 6) iv = int'($urandom_range(0, (1 << 19) - 1)) - (1 << 18);
    else if (mn == 7 || mn == 8) iv = int'($urandom_range(0, (1 << 26) - 1)) - (1 << 25);
    send(mn, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), iv, 1'b0,
         $urandom_range(0, 2));
  endtask

  initial begin
    tick();
    tick();
    chk("rst_ready", 32'(ready), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_code", 32'(errcode), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_data", data, 0);
    chk("rst_addr", 32'(addr), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(ready), 0);
    restart();
    send(0, 1, 2, 3, 0, 1'b0, 0);
    chk("lit_add", data, 32'h8B030041);
    send(4, 5, 6, 0, -8, 1'b0, 0);
    chk("lit_ldur", data, 32'hF85F80C5);
    send(6, 9, 0, 0, -2, 1'b0, 5);
    chk("lit_cbz", data, 32'hB4FFFFC9);
    send(7, 0, 0, 0, 16, 1'b0, 1);
    chk("lit_b", data, 32'h14000010);
    send(8, 0, 0, 0, 16, 1'b0, 0);
    chk("lit_bl", data, 32'h94000010);
    send(9, 0, 30, 0, 0, 1'b0, 0);
    chk("lit_br", data, 32'hD61F03C0);
    send(4, 1, 2, 0, 256, 1'b0, 0);
    send(12, 1, 2, 3, 0, 1'b0, 0);
    send(5, 1, 2, 0, -257, 1'b0, 0);
    send(0, 4, 5, 6, 0, 1'b0, 0);
    restart();
    start = 1'b1; valid = 1'b1; mnem = 4'd0;
    tick();
    start = 1'b0; valid = 1'b0;
    chk("start_over_valid_we", 32'(we), 0);
    chk("start_over_valid_ready", 32'(ready), 1);
    while (m_cnt < 64) send_rand();
    chk("full_addr_count", 32'(count), 64);
    send(0, 1, 2, 3, 0, 1'b0, 0);
    send(0, 1, 2, 3, 0, 1'b1, 0);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("done_ignore_we", 32'(we), 0);
    chk("done_ignore_count", 32'(count), 64);
    chk("done_hold", 32'(done), 1);
    restart();
    send(3, 7, 8, 9, 0, 1'b1, 0);
    chk("last_write_count", 32'(count), 1);
    restart();
    mnem = 4'd1; rd = 5'd1; rn = 5'd1; rm = 5'd1; valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("midwrite_we", 32'(we), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_we", 32'(we), 0);
    chk("midrst_ready", 32'(ready), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_data", data, 0);
    chk("midrst_addr", 32'(addr), 0);
    chk("midrst_count", 32'(count), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
